// File: rtl/multicycle_ctrl.sv
// Moore controller for a multicycle MIPS-subset datapath: sequences fetch,
// decode, memory, ALU, branch and jump steps and decodes their control strobes.
module multicycle_ctrl #(
  parameter bit BNE_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP
  } state_e;

  state_e state_q, state_d;

  // Unused encodings 12..15 fall into the default arm and recover to FETCH.
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:   state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_BNE:       state_d = BNE_EN ? BRANCH : FETCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:  state_d = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   state_d = MEMWB;
      EXECUTE: state_d = ALUWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  // NOTE: state uses non-blocking assignment with the async reset in the
  // sensitivity list so the FSM drops to FETCH the moment reset goes low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  logic [2:0] funct_alu;
  logic       funct_legal;

  always_comb begin
    funct_legal = 1'b1;
    case (funct)
      6'b100000: funct_alu = 3'b010;
      6'b100010: funct_alu = 3'b110;
      6'b100100: funct_alu = 3'b000;
      6'b100101: funct_alu = 3'b001;
      6'b101010: funct_alu = 3'b111;
      default: begin
        funct_alu   = 3'b000;
        funct_legal = 1'b0;
      end
    endcase
  end

  logic pcen_s, memwrite_s, irwrite_s, regwrite_s;

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    pcen_s     = 1'b0;
    memwrite_s = 1'b0;
    irwrite_s  = 1'b0;
    regwrite_s = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    alucontrol = 3'b000;
    case (state_q)
      FETCH: begin
        alusrcb    = 2'b01;
        alucontrol = 3'b010;
        irwrite_s  = 1'b1;
        pcen_s     = 1'b1;
      end
      DECODE: begin
        alusrcb    = 2'b11;
        alucontrol = 3'b010;
      end
      MEMADR, ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = 3'b010;
      end
      MEMRD: iord = 1'b1;
      MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_s = 1'b1;
      end
      MEMWR: begin
        iord       = 1'b1;
        memwrite_s = 1'b1;
      end
      EXECUTE: begin
        alusrca    = 1'b1;
        alucontrol = funct_alu;
      end
      ALUWB: begin
        regdst     = 1'b1;
        regwrite_s = funct_legal;
      end
      BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = 3'b110;
        pcsrc      = 2'b01;
        pcen_s     = (op == OP_BEQ) ? zero : ~zero;
      end
      ADDIWB: regwrite_s = 1'b1;
      JUMP: begin
        pcsrc  = 2'b10;
        pcen_s = 1'b1;
      end
      default: ;
    endcase
  end

  // Enables are gated by reset directly so they fall without waiting for clk.
  assign pcen     = pcen_s & reset;
  assign memwrite = memwrite_s & reset;
  assign irwrite  = irwrite_s & reset;
  assign regwrite = regwrite_s & reset;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: an instruction-level model queues the
// expected per-cycle control vectors and a negedge monitor compares them.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
  } ctl_t;

  typedef struct {
    ctl_t       v;
    logic [5:0] op;
    int         idx;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic reset0 = 1'b0;
  logic [5:0] op = 6'b0, funct = 6'b0;
  logic zero = 1'b0;

  logic pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic pcen0, memwrite0, irwrite0, regwrite0, iord0, memtoreg0, regdst0, alusrca0;
  logic [1:0] alusrcb0, pcsrc0;
  logic [2:0] alucontrol0;

  ctl_t act, act0;
  assign act  = {pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca,
                 alusrcb, pcsrc, alucontrol};
  assign act0 = {pcen0, memwrite0, irwrite0, regwrite0, iord0, memtoreg0, regdst0, alusrca0,
                 alusrcb0, pcsrc0, alucontrol0};

  multicycle_ctrl #(.BNE_EN(1'b1)) u_dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol)
  );

  multicycle_ctrl #(.BNE_EN(1'b0)) u_dut0 (
    .clk(clk), .reset(reset0), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen0), .memwrite(memwrite0), .irwrite(irwrite0), .regwrite(regwrite0),
    .iord(iord0), .memtoreg(memtoreg0), .regdst(regdst0), .alusrca(alusrca0),
    .alusrcb(alusrcb0), .pcsrc(pcsrc0), .alucontrol(alucontrol0)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, actual, required, $time);
    end
  endtask

  function automatic ctl_t mk(input logic pc, mw, ir, rw, id, mr, rd, sa,
                              input logic [1:0] sb, ps, input logic [2:0] ac);
    ctl_t c;
    c = {pc, mw, ir, rw, id, mr, rd, sa, sb, ps, ac};
    return c;
  endfunction

  // ALU operation and legality for an R-type funct; unknown functs drive 000.
  function automatic logic [3:0] alu_of(input logic [5:0] f);
    case (f)
      6'b100000: return {1'b1, 3'b010};
      6'b100010: return {1'b1, 3'b110};
      6'b100100: return {1'b1, 3'b000};
      6'b100101: return {1'b1, 3'b001};
      6'b101010: return {1'b1, 3'b111};
      default:   return {1'b0, 3'b000};
    endcase
  endfunction

  // Instruction-level reference: the control vector of each cycle of one instruction.
  function automatic void model(input logic [5:0] o, input logic [5:0] f, input logic z,
                                input bit bne_en, ref ctl_t seq[$]);
    ctl_t fetch_v, decode_v, adr_v;
    logic [3:0] a;
    fetch_v  = mk(1,0,1,0,0,0,0,0, 2'b01, 2'b00, 3'b010);
    decode_v = mk(0,0,0,0,0,0,0,0, 2'b11, 2'b00, 3'b010);
    adr_v    = mk(0,0,0,0,0,0,0,1, 2'b10, 2'b00, 3'b010);
    a = alu_of(f);
    seq = '{fetch_v, decode_v};
    case (o)
      6'b100011: begin
        seq.push_back(adr_v);
        seq.push_back(mk(0,0,0,0,1,0,0,0, 2'b00, 2'b00, 3'b000));
        seq.push_back(mk(0,0,0,1,0,1,0,0, 2'b00, 2'b00, 3'b000));
      end
      6'b101011: begin
        seq.push_back(adr_v);
        seq.push_back(mk(0,1,0,0,1,0,0,0, 2'b00, 2'b00, 3'b000));
      end
      6'b000000: begin
        seq.push_back(mk(0,0,0,0,0,0,0,1, 2'b00, 2'b00, a[2:0]));
        seq.push_back(mk(0,0,0,a[3],0,0,1,0, 2'b00, 2'b00, 3'b000));
      end
      6'b000100: seq.push_back(mk(z,0,0,0,0,0,0,1, 2'b00, 2'b01, 3'b110));
      6'b000101: if (bne_en) seq.push_back(mk(~z,0,0,0,0,0,0,1, 2'b00, 2'b01, 3'b110));
      6'b001000: begin
        seq.push_back(adr_v);
        seq.push_back(mk(0,0,0,1,0,0,0,0, 2'b00, 2'b00, 3'b000));
      end
      6'b000010: seq.push_back(mk(1,0,0,0,0,0,0,0, 2'b00, 2'b10, 3'b000));
      default: ;
    endcase
  endfunction

  // Drive one instruction from a FETCH cycle and queue its expected vectors.
  task automatic issue(input logic [5:0] o, input logic [5:0] f, input logic z);
    ctl_t seq[$];
    op = o; funct = f; zero = z;
    model(o, f, z, 1'b1, seq);
    foreach (seq[i]) exp_q.push_back('{v: seq[i], op: o, idx: i});
    repeat (seq.size()) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en && reset) begin
      check("we_exclusive", 32'(int'(memwrite) + int'(regwrite) + int'(irwrite) <= 1), 32'd1);
      if (exp_q.size() == 0) begin
        check("queue_underflow", 32'd0, 32'd1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check($sformatf("ctl op=%b cyc=%0d", e.op, e.idx + 1), 32'(act), 32'(e.v));
      end
    end
  end

  task automatic bne_disabled_check();
    reset0 = 1'b1;
    @(negedge clk);
    check("bne0_fetch_ir", 32'(irwrite0), 32'd1);
    @(negedge clk);
    check("bne0_decode_b", 32'(alusrcb0), 32'(2'b11));
    @(negedge clk);
    check("bne0_back_fetch", 32'(act0), 32'(mk(1,0,1,0,0,0,0,0, 2'b01, 2'b00, 3'b010)));
    reset0 = 1'b0;
  endtask

  logic [5:0] legal_ops[7] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                               6'b000101, 6'b001000, 6'b000010};
  logic [5:0] legal_f[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_enables", 32'({pcen, memwrite, irwrite, regwrite}), 32'd0);
    check("rst_fetch_mux", 32'({iord, alusrca, alusrcb, pcsrc, alucontrol}), 32'({1'b0, 1'b0, 2'b01, 2'b00, 3'b010}));
    reset = 1'b1;
    mon_en = 1'b1;

    issue(6'b100011, 6'b0, 1'b0);
    issue(6'b101011, 6'b0, 1'b0);
    issue(6'b000000, 6'b101010, 1'b0);
    issue(6'b000000, 6'b000111, 1'b0);
    issue(6'b000100, 6'b0, 1'b1);
    issue(6'b000100, 6'b0, 1'b0);
    fork
      issue(6'b000101, 6'b0, 1'b0);
      bne_disabled_check();
    join
    issue(6'b000101, 6'b0, 1'b1);
    issue(6'b001000, 6'b0, 1'b0);
    issue(6'b000010, 6'b0, 1'b0);
    issue(6'b111111, 6'b0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      logic [5:0] o, f;
      o = legal_ops[$urandom_range(6)];
      if ($urandom_range(7) == 0) begin
        o = 6'($urandom);
        while (o inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101,
                         6'b001000, 6'b000010}) o = 6'($urandom);
      end
      f = ($urandom_range(4) == 0) ? 6'($urandom) : legal_f[$urandom_range(4)];
      issue(o, f, 1'($urandom));
    end

    // Reset pulse in the middle of a store.
    mon_en = 1'b0;
    op = 6'b101011; funct = 6'b0; zero = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("memwr_before_pulse", 32'({memwrite, iord}), 32'd3);
    reset = 1'b0;
    op = 6'b111111;
    #1;
    check("memwr_drop_in_pulse", 32'({memwrite, irwrite, pcen, regwrite}), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check("fetch_after_pulse", 32'(act), 32'(mk(1,0,1,0,0,0,0,0, 2'b01, 2'b00, 3'b010)));
    @(posedge clk);
    #1;
    check("decode_after_pulse", 32'(act), 32'(mk(0,0,0,0,0,0,0,0, 2'b11, 2'b00, 3'b010)));
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    issue(6'b100011, 6'b0, 1'b0);
    issue(6'b000010, 6'b0, 1'b0);

    mon_en = 1'b0;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: BNE_EN, default 1, meaning 1 = bne decoded as a branch, 0 = opcode 000101 treated as illegal.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; 0 forces state FETCH immediately, independent of clk.
REQ-004 op  input  6  instruction opcode field (instr[31:26]) from the instruction register.
REQ-005 funct  input  6  R-type function field (instr[5:0]).
REQ-006 zero  input  1  ALU zero flag from the datapath.
REQ-007 pcen  output  1  PC register write enable.
REQ-008 memwrite  output  1  memory write strobe.
REQ-009 irwrite  output  1  instruction register write enable.
REQ-010 regwrite  output  1  register file write enable.
REQ-011 iord  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-012 memtoreg  output  1  writeback select: 1 = data register, 0 = ALUOut.
REQ-013 regdst  output  1  destination select: 1 = rd, 0 = rt.
REQ-014 alusrca  output  1  ALU A select: 0 = PC, 1 = register A.
REQ-015 alusrcb  output  2  ALU B select: 00 = B reg, 01 = constant 4, 10 = sign-ext imm, 11 = imm<<2.
REQ-016 pcsrc  output  2  PC next select: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
REQ-017 alucontrol  output  3  ALU op: 010 add, 110 sub, 000 and, 001 or, 111 slt.

Function
REQ-018 The block SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP; all outputs are combinational from state, plus zero for pcen and funct for alucontrol.
REQ-019 FETCH: iord=0, alusrca=0, alusrcb=01, alucontrol=010, pcsrc=00, irwrite=1, pcen=1; next DECODE.
REQ-020 DECODE: alusrca=0, alusrcb=11, alucontrol=010; next by op: 100011/101011->MEMADR, 000000->EXECUTE, 000100->BRANCH, 000101->BRANCH if BNE_EN=1, 001000->ADDIEX, 000010->JUMP, any other->FETCH.
REQ-021 MEMADR: alusrca=1, alusrcb=10, alucontrol=010; next MEMRD if op=100011, else MEMWR.
REQ-022 MEMRD: iord=1; next MEMWB. MEMWB: regdst=0, memtoreg=1, regwrite=1; next FETCH.
REQ-023 MEMWR: iord=1, memwrite=1; next FETCH.
REQ-024 EXECUTE: alusrca=1, alusrcb=00, alucontrol per funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt); next ALUWB.
REQ-025 ALUWB: regdst=1, memtoreg=0, regwrite=1 only if funct is one of the five legal codes, else regwrite=0; next FETCH.
REQ-026 BRANCH: alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01, pcen = zero for beq, ~zero for bne; next FETCH.
REQ-027 ADDIEX: alusrca=1, alusrcb=10, alucontrol=010; next ADDIWB. ADDIWB: regdst=0, memtoreg=0, regwrite=1; next FETCH.
REQ-028 JUMP: pcsrc=10, pcen=1; next FETCH.
REQ-029 Every output not listed for a state SHALL be 0; unreachable state encodings SHALL transition to FETCH with all enables 0.
REQ-030 Cycles per instruction: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3, illegal opcode 2.
REQ-031 At most one of memwrite, regwrite, irwrite SHALL be 1 in any cycle.

Reset
REQ-032 While reset=0: state=FETCH and pcen, memwrite, irwrite, regwrite forced to 0; other outputs show FETCH values.
REQ-033 Reset assertion mid-instruction (e.g. in MEMWR) SHALL deassert memwrite combinationally without waiting for clk.
REQ-034 First rising edge after reset returns to 1 SHALL be a FETCH cycle with irwrite=1, pcen=1.

Verification
REQ-035 Release reset, op=100011 -> states FETCH,DECODE,MEMADR,MEMRD,MEMWB; regwrite=1, memtoreg=1 only in cycle 5; back to FETCH cycle 6.
REQ-036 op=101011 -> memwrite=1, iord=1 exactly in cycle 4, never elsewhere.
REQ-037 op=000000, funct=101010 -> EXECUTE alucontrol=111; ALUWB regdst=1, regwrite=1; funct=000111 -> ALUWB regwrite=0.
REQ-038 op=000100 with zero=1 -> BRANCH pcen=1, pcsrc=01; zero=0 -> pcen=0; op=000101 zero=0 -> pcen=1 (BNE_EN=1), FETCH after DECODE when BNE_EN=0.
REQ-039 op=000010 -> JUMP pcen=1, pcsrc=10; op=111111 -> DECODE->FETCH, no write enable asserted.
REQ-040 reset pulsed low for 3 ns during MEMWR -> memwrite drops within the pulse; next active edge is FETCH.
